// File: rtl/mdio_master.sv
// ---------------------------------------------------------------------------
// mdio_master
//   Clause 22 MDIO management master. Takes one register read or write command
//   over a valid/ready handshake, runs the 64-bit serial frame on MDC/MDIO, and
//   reports completion with a single-cycle response pulse.
//
// Ports
//   aclk, aresetn        system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_write            1 = write, 0 = read
//   cmd_reg, cmd_wdata   register address and write data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata, rsp_err   read data and "no PHY answered" flag (0 for writes);
//                        both hold until the next completion
//   mdc                  management clock (idle low)
//   mdio_o, mdio_oe      pad output data and output enable (1 = drive)
//   mdio_i               pad input, synchronised internally
// ---------------------------------------------------------------------------
module mdio_master #(
    parameter int         CLK_DIV  = 20,
    parameter logic [4:0] PHY_ADDR = 5'h01
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic          mdc_q, mdc_d;
    logic          mdio_o_q, mdio_o_d;
    logic          mdio_oe_q, mdio_oe_d;
    // Frame bits still to be sent; the bit currently on the wire lives in mdio_o_q.
    logic [62:0]   tx_q, tx_d;
    logic          write_q, write_d;
    logic [15:0]   rx_q, rx_d;
    logic          ta_q, ta_d;
    logic [15:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic [1:0]    sync_q, sync_d;
    logic [63:0]   frame;

    // Full frame for the command being offered; only used on the accept edge.
    // Released positions of a read (TA, data) are filled with 1s but never driven.
    assign frame = {32'hFFFF_FFFF, 2'b01,
                    (cmd_write ? 2'b01 : 2'b10),
                    PHY_ADDR, cmd_reg,
                    (cmd_write ? 2'b10 : 2'b11),
                    (cmd_write ? cmd_wdata : 16'hFFFF)};

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        mdc_d       = mdc_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        tx_d        = tx_q;
        write_d     = write_q;
        rx_d        = rx_q;
        ta_d        = ta_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        sync_d      = {sync_q[0], mdio_i};

        case (state_q)
            S_IDLE: begin
                mdc_d     = 1'b0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b0;
                if (cmd_valid) begin
                    state_d   = S_SHIFT;
                    write_d   = cmd_write;
                    div_d     = '0;
                    bit_d     = 6'd0;
                    tx_d      = frame[62:0];
                    mdio_o_d  = frame[63];
                    mdio_oe_d = 1'b1;
                    rx_d      = 16'h0000;
                    ta_d      = 1'b0;
                end
            end
            S_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!mdc_q) begin
                        // Rising MDC: sample the PHY while data is centred in the bit.
                        mdc_d = 1'b1;
                        if (!write_q) begin
                            if (bit_q == 6'd47) begin
                                ta_d = sync_q[1];
                            end else if (bit_q >= 6'd48) begin
                                rx_d = {rx_q[14:0], sync_q[1]};
                            end
                        end
                    end else begin
                        // Falling MDC: the only place the pad data/enable change.
                        mdc_d = 1'b0;
                        if (bit_q == 6'd63) begin
                            state_d     = S_DONE;
                            mdio_o_d    = 1'b1;
                            mdio_oe_d   = 1'b0;
                            rsp_rdata_d = write_q ? 16'h0000 : rx_q;
                            rsp_err_d   = write_q ? 1'b0 : ta_q;
                        end else begin
                            bit_d     = bit_q + 6'd1;
                            tx_d      = {tx_q[61:0], 1'b1};
                            mdio_o_d  = tx_q[62];
                            // Reads hand the bus to the PHY from bit 46 onwards.
                            mdio_oe_d = write_q || (bit_q < 6'd45);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mdc_d     = 1'b0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= 6'd0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            tx_q        <= '0;
            write_q     <= 1'b0;
            rx_q        <= 16'h0000;
            ta_q        <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
            sync_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            mdc_q       <= mdc_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            tx_q        <= tx_d;
            write_q     <= write_d;
            rx_q        <= rx_d;
            ta_q        <= ta_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            sync_q      <= sync_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// ---------------------------------------------------------------------------
// tb_mdio_master
//   Self-checking bench for mdio_master (CLK_DIV=4, PHY_ADDR=1). A monitor
//   captures the pad state at every MDC rise and plays a simple PHY; the main
//   sequence compares captured frames and responses against a frame model
//   built from the Clause 22 field layout.
// ---------------------------------------------------------------------------
module tb_mdio_master;

    localparam int         D    = 4;
    localparam logic [4:0] PHYA = 5'h01;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    // PHY model state (written by monitor) and configuration (written by main)
    logic        phy_val = 1'b1;
    bit          phy_en;
    logic [15:0] phy_data;

    // Pad: the master's own value when it drives, otherwise the PHY (pull-up = 1)
    assign mdio_i = mdio_oe ? mdio_o : phy_val;

    mdio_master #(.CLK_DIV(D), .PHY_ADDR(PHYA)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mdc       (mdc),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- monitor / PHY model ----------------
    int          nbits = 0;
    logic [63:0] cap_o = '0, cap_oe = '0;
    int          rsp_cnt = 0, rsp_cyc = 0;
    logic [15:0] rsp_rdata_s = '0;
    logic        rsp_err_s = 1'b0;
    int          order_viol = 0, ready_viol = 0;
    bit          busy = 0;
    logic        prev_mdc = 1'b0, prev_o = 1'b1, prev_oe = 1'b0;

    function automatic logic phy_bit(input int k);
        if (phy_en && k == 47)             return 1'b0;
        if (phy_en && k >= 48 && k <= 63)  return phy_data[63 - k];
        return 1'b1;
    endfunction

    always @(negedge aclk) begin
        if (!aresetn) begin
            busy    = 0;
            phy_val = 1'b1;
        end else begin
            // Output enable rises only at the start of bit 0 of a frame.
            if (mdio_oe && !prev_oe) begin
                nbits   = 0;
                cap_o   = '0;
                cap_oe  = '0;
                busy    = 1;
                phy_val = 1'b1;
            end
            if (mdc && !prev_mdc) begin
                if (nbits < 64) begin
                    cap_o[63 - nbits]  = mdio_o;
                    cap_oe[63 - nbits] = mdio_oe;
                end
                nbits++;
                phy_val = phy_bit(nbits);   // PHY updates after the rising edge
            end
            if (mdc && ((mdio_o !== prev_o) || (mdio_oe !== prev_oe))) order_viol++;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc     = cyc;
                rsp_rdata_s = rsp_rdata;
                rsp_err_s   = rsp_err;
                busy        = 0;
            end else if (busy && cmd_ready) begin
                ready_viol++;
            end
        end
        prev_mdc = mdc;
        prev_o   = mdio_o;
        prev_oe  = mdio_oe;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model of the current transaction
    bit          m_wr;
    logic [63:0] m_frame, m_oe;
    logic [15:0] m_rdata;
    logic        m_err;
    int          t_acc = 0, rsp_base = 0;

    task automatic set_model(input bit wr, input logic [4:0] r, input logic [15:0] d,
                             input bit phy, input logic [15:0] pd);
        logic [1:0] op;
        op       = wr ? 2'b01 : 2'b10;
        m_wr     = wr;
        m_frame  = {32'hFFFF_FFFF, 2'b01, op, PHYA, r, 2'b10, d};
        m_oe     = wr ? {64{1'b1}} : ({64{1'b1}} << 18);
        m_rdata  = wr ? 16'h0000 : (phy ? pd : 16'hFFFF);
        m_err    = wr ? 1'b0 : !phy;
        phy_en   = !wr && phy;
        phy_data = pd;
    endtask

    task automatic drive_cmd(input bit wr, input logic [4:0] r, input logic [15:0] d);
        cmd_write = wr;
        cmd_reg   = r;
        cmd_wdata = d;
    endtask

    task automatic wait_accept();
        bit r;
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            r = cmd_ready;
            @(posedge aclk);
            #1;
            if (r) begin ok = 1; break; end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        t_acc    = cyc;
        rsp_base = rsp_cnt;
    endtask

    task automatic finish_cmd();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            #1;
            if (rsp_cnt != rsp_base) begin ok = 1; break; end
        end
        check("rsp_timeout", 64'(ok), 64'd1);
        @(negedge aclk);
        #1;
        check("rsp_pulses", 64'(rsp_cnt - rsp_base), 64'd1);
        check("rsp_latency", 64'(rsp_cyc - t_acc), 64'(128 * D));
        check("frame_bits", 64'(nbits), 64'd64);
        check("frame_oe", cap_oe, m_oe);
        check("frame_data", cap_o & m_oe, m_frame & m_oe);
        check("rsp_rdata", 64'(rsp_rdata_s), 64'(m_rdata));
        check("rsp_err", 64'(rsp_err_s), 64'(m_err));
        check("ready_busy", 64'(ready_viol), 64'd0);
        check("mdio_stable", 64'(order_viol), 64'd0);
        $display("txn %s reg=%0d wdata=%04h -> rdata=%04h err=%0b latency=%0d",
                 m_wr ? "WR" : "RD", cmd_reg, cmd_wdata, rsp_rdata_s, rsp_err_s, rsp_cyc - t_acc);
    endtask

    task automatic run_cmd(input bit wr, input logic [4:0] r, input logic [15:0] d,
                           input bit phy, input logic [15:0] pd);
        set_model(wr, r, d, phy, pd);
        drive_cmd(wr, r, d);
        cmd_valid = 1'b1;
        wait_accept();
        cmd_valid = 1'b0;
        finish_cmd();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr, phy;
        logic [4:0]  r;
        logic [15:0] d, pd;
        int          prev_rsp, bad;

        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_reg   = 5'd0;
        cmd_wdata = 16'h0000;
        phy_en    = 0;
        phy_data  = 16'h0000;

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mdc", 64'(mdc), 64'd0);
        check("rst_mdio_o", 64'(mdio_o), 64'd1);
        check("rst_mdio_oe", 64'(mdio_oe), 64'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        #1;

        // Directed: write, read with PHY, read without PHY
        run_cmd(1'b1, 5'd0, 16'h1200, 1'b0, 16'h0000);
        run_cmd(1'b0, 5'd2, 16'h0000, 1'b1, 16'h0007);
        run_cmd(1'b0, 5'd9, 16'h0000, 1'b0, 16'h0000);

        // Randomized transactions
        for (int i = 0; i < 6; i++) begin
            wr  = $urandom_range(0, 1) == 1;
            r   = 5'($urandom);
            d   = 16'($urandom);
            phy = $urandom_range(0, 3) != 0;
            pd  = 16'($urandom);
            run_cmd(wr, r, d, phy, pd);
        end

        // Back-to-back with cmd_valid held high
        d  = 16'($urandom);
        pd = 16'($urandom);
        set_model(1'b1, 5'd4, d, 1'b0, 16'h0000);
        drive_cmd(1'b1, 5'd4, d);
        cmd_valid = 1'b1;
        wait_accept();
        drive_cmd(1'b0, 5'd5, 16'h0000);
        finish_cmd();
        set_model(1'b0, 5'd5, 16'h0000, 1'b1, pd);
        prev_rsp = rsp_cyc;
        wait_accept();
        cmd_valid = 1'b0;
        check("b2b_accept_gap", 64'(t_acc - prev_rsp), 64'd2);
        finish_cmd();
        check("b2b_rsp_spacing", 64'(rsp_cyc - prev_rsp), 64'(128 * D + 2));

        // Reset in the middle of bit 40 of a read
        set_model(1'b0, 5'd3, 16'h0000, 1'b1, 16'hBEEF);
        drive_cmd(1'b0, 5'd3, 16'h0000);
        cmd_valid = 1'b1;
        wait_accept();
        cmd_valid = 1'b0;
        bad = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            #1;
            if (nbits >= 41) begin bad = 0; break; end
        end
        check("midrst_reach_bit40", 64'(bad), 64'd0);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_mdc", 64'(mdc), 64'd0);
        check("midrst_mdio_oe", 64'(mdio_oe), 64'd0);
        check("midrst_mdio_o", 64'(mdio_o), 64'd1);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge aclk);
        #1;
        check("midrst_no_rsp", 64'(rsp_cnt - rsp_base), 64'd0);
        aresetn = 1'b1;
        $display("txn RESET during bit 40 -> frame aborted, rsp pulses=%0d", rsp_cnt - rsp_base);
        repeat (2) @(negedge aclk);
        #1;
        run_cmd(1'b0, 5'd3, 16'h0000, 1'b1, 16'($urandom));

        // Idle: no activity for 1000 cycles
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge aclk);
            #1;
            if (mdc !== 1'b0 || mdio_oe !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        check("idle_quiet", 64'(bad), 64'd0);
        $display("txn IDLE 1000 cycles -> bad cycles=%0d", bad);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- IEEE 802.3 Clause 22 MDIO management master.
- Drives the PHY's ETH_MDC/ETH_MDIO pins, which the ethernet top exposes but currently leaves undriven.
- Accepts register read/write commands over a valid/ready handshake and runs the serial frame on MDC/MDIO.
- Returns read data and completion as a one-cycle response pulse.
- The MDIO tristate buffer is instantiated at the top level (mdio_o/mdio_oe/mdio_i).

Parameters:
- CLK_DIV, 20: aclk cycles per MDC half-period. Legal range is ≥4. The default gives 2.5 MHz MDC at 100 MHz aclk.
- PHY_ADDR, 5'h01: PHY address inserted in every frame.

Ports:
- aclk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1=write, 0=read
- cmd_reg  in  5  register address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data, valid with rsp_valid; 0 for writes
- rsp_err  out  1  read: no PHY drove the TA low bit; 0 for writes
- mdc  out  1  management clock
- mdio_o  out  1  MDIO output data
- mdio_oe  out  1  MDIO output enable; 1 = drive
- mdio_i  in  1  MDIO input from pad

Behaviour:
- Reset (async, aresetn=0):
  - State IDLE; cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mdc=0, mdio_o=1, mdio_oe=0; counters and shift registers cleared.
  - Reset mid-frame aborts the frame immediately and produces no rsp_valid.
- Synchronizer: mdio_i passes through a 2-flop synchronizer, which is reset to 1. All sampling uses the synchronized value.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - cmd_ready=1, mdc=0, mdio_oe=0, mdio_o=1.
  - Accept on the edge T where cmd_valid && cmd_ready. Latch cmd_write, cmd_reg, cmd_wdata; go to SHIFT; cmd_ready=0 from T.
- SHIFT: 64 bits, index k=0..63. Bit k occupies cycles T+1+2k·D .. T+2(k+1)·D, where D=CLK_DIV.
  - mdc is 0 for the first D cycles of a bit and 1 for the last D cycles.
  - mdio_o/mdio_oe change only on the edge where mdc goes 1->0 (or enters the first bit), so they are stable across the MDC rising edge.
- Frame content, MSB first:
  - k=0..31: preamble, all 1s.
  - k=32..33: ST = 01.
  - k=34..35: OP = 01 (write) or 10 (read).
  - k=36..40: PHY_ADDR.
  - k=41..45: cmd_reg.
  - k=46..47: TA. Write drives 10; read releases the bus.
  - k=48..63: write drives cmd_wdata; read releases the bus.
- Output enable:
  - Write: mdio_oe=1 for k=0..63.
  - Read: mdio_oe=1 for k=0..45 and 0 for k=46..63.
- Read sampling: synchronized mdio_i is captured on the edge where mdc goes 0->1.
  - k=47: TA sample. rsp_err = sample value, so 1 means no PHY.
  - k=48..63: shifted into the rdata register MSB first.
- DONE:
  - After bit 63's high phase ends, the block enters DONE for exactly one cycle, T+128D+1.
  - In DONE: rsp_valid=1, rsp_rdata/rsp_err valid; mdc=0, mdio_oe=0, mdio_o=1.
  - The next cycle is IDLE with cmd_ready=1.
  - No rsp_ready: the consumer must accept the pulse.
- rsp_rdata and rsp_err hold their last values until the next DONE.
- Commands presented while busy are ignored; the handshake simply stalls. A held cmd_valid is accepted on the first IDLE cycle after DONE.
- mdc does not toggle outside SHIFT.

Test Plan:
- Write (CLK_DIV=4, PHY_ADDR=1): reg 0, wdata 0x1200 -> mdio_oe=1 for all 64 bits.
  - Bits sampled at mdc rises: 32×1, then 0101 00001 00000 10 0001001000000000.
  - rsp_valid high only at T+513, with rsp_rdata=0 and rsp_err=0.
- Read: PHY model drives TA bit 47 = 0 and data 0x0007 for reg 2 -> OP bits 10, REGAD 00010.
  - mdio_oe falls at the start of bit 46.
  - rsp_valid at T+513 with rsp_rdata=0x0007, rsp_err=0.
- Read, no PHY (mdio_i held 1) -> rsp_rdata=0xFFFF, rsp_err=1.
- Back-to-back: cmd_valid held high with two commands.
  - Second accepted on the cycle after rsp_valid.
  - cmd_ready=0 throughout SHIFT.
  - Exactly two rsp_valid pulses, 514 cycles apart.
- Reset mid-frame: aresetn=0 during bit 40 -> mdc=0, mdio_oe=0, mdio_o=1 immediately with no clock edge; no rsp_valid.
  - After release, a read of reg 3 completes normally.
- Idle check: no command for 1000 cycles -> mdc constant 0, mdio_oe=0, cmd_ready=1.
